// File: rtl/puzzle_board_keeper.sv
// Live 3x3 sliding-puzzle board: loads and validates a preset layout, then
// applies player moves by swapping the blank with a neighbour, counts the
// legal moves and flags the solved arrangement 1..8,0.
module puzzle_board_keeper #(
  parameter int CNT_W = 10
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_load,
  input  logic [3:0]       I_cell1,
  input  logic [3:0]       I_cell2,
  input  logic [3:0]       I_cell3,
  input  logic [3:0]       I_cell4,
  input  logic [3:0]       I_cell5,
  input  logic [3:0]       I_cell6,
  input  logic [3:0]       I_cell7,
  input  logic [3:0]       I_cell8,
  input  logic [3:0]       I_cell9,
  input  logic             I_move_valid,
  input  logic [1:0]       I_move_dir,
  output logic [3:0]       O_cell1,
  output logic [3:0]       O_cell2,
  output logic [3:0]       O_cell3,
  output logic [3:0]       O_cell4,
  output logic [3:0]       O_cell5,
  output logic [3:0]       O_cell6,
  output logic [3:0]       O_cell7,
  output logic [3:0]       O_cell8,
  output logic [3:0]       O_cell9,
  output logic [3:0]       O_blank_pos,
  output logic [CNT_W-1:0] O_move_cnt,
  output logic             O_ready,
  output logic             O_busy,
  output logic             O_solved,
  output logic             O_err,
  output logic             O_move_ack,
  output logic             O_illegal
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SCAN, READY, SETTLE, SOLVED, ERR
  } state_t;

  state_t     state, state_next;
  logic [3:0] board   [9];
  logic [3:0] cell_in [9];
  logic [8:0] seen, seen_next;
  logic       bad, bad_next;
  logic [3:0] scan_idx;
  logic [3:0] cur_val;
  logic       scan_valid;
  logic       board_solved;
  logic       move_legal;
  logic [3:0] pos, target;

  // Gather the preset inputs and expose the board as flat output ports.
  always_comb begin
    cell_in = '{I_cell1, I_cell2, I_cell3, I_cell4, I_cell5,
                I_cell6, I_cell7, I_cell8, I_cell9};
    {O_cell1, O_cell2, O_cell3} = {board[0], board[1], board[2]};
    {O_cell4, O_cell5, O_cell6} = {board[3], board[4], board[5]};
    {O_cell7, O_cell8, O_cell9} = {board[6], board[7], board[8]};
  end

  // Scan step: fold the current cell into the seen mask and compare the board
  // against the solved layout.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    cur_val      = board[scan_idx];
    seen_next    = seen;
    bad_next     = bad;
    board_solved = 1'b1;
    if (cur_val > 4'd8) bad_next = 1'b1;
    else                seen_next[cur_val] = 1'b1;
    scan_valid = (seen_next == 9'h1FF) && !bad_next;
    for (int i = 0; i < 9; i++) begin
      if (board[i] != ((i == 8) ? 4'd0 : 4'(i + 1))) board_solved = 1'b0;
    end
  end

  // Move legality from the blank's row/column and the neighbour to swap with.
  always_comb begin
    pos        = O_blank_pos - 4'd1;
    target     = pos;
    move_legal = 1'b0;
    if (O_blank_pos != 4'd0) begin
      unique case (I_move_dir)
        2'd0: begin move_legal = (pos >= 4'd3); target = pos - 4'd3; end
        2'd1: begin move_legal = (pos <= 4'd5); target = pos + 4'd3; end
        2'd2: begin
          move_legal = (pos != 4'd0) && (pos != 4'd3) && (pos != 4'd6);
          target     = pos - 4'd1;
        end
        2'd3: begin
          move_legal = (pos != 4'd2) && (pos != 4'd5) && (pos != 4'd8);
          target     = pos + 4'd1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge I_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (I_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_next = state;
    O_ready    = (state == READY);
    O_busy     = (state == LOAD) || (state == SCAN) || (state == SETTLE);
    if (I_load) begin
      state_next = LOAD;
    end else begin
      unique case (state)
        LOAD:   state_next = SCAN;
        SCAN:   if (scan_idx == 4'd8)
                  state_next = !scan_valid ? ERR : (board_solved ? SOLVED : READY);
        READY:  if (I_move_valid && move_legal) state_next = SETTLE;
        SETTLE: state_next = board_solved ? SOLVED : READY;
        default: state_next = state;
      endcase
    end
  end

  // Board, scan bookkeeping, counter and registered flags.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      // NOTE: the board is a handful of flops, not a RAM, so it is reset along
      // with everything else and reads back as zeros after reset.
      for (int i = 0; i < 9; i++) board[i] <= 4'd0;
      seen        <= '0;
      bad         <= 1'b0;
      scan_idx    <= 4'd0;
      O_blank_pos <= 4'd0;
      O_move_cnt  <= '0;
      O_solved    <= 1'b0;
      O_err       <= 1'b0;
      O_move_ack  <= 1'b0;
      O_illegal   <= 1'b0;
    end else begin
      O_move_ack <= 1'b0;
      O_illegal  <= 1'b0;
      if (I_load) begin
        O_move_cnt  <= '0;
        O_solved    <= 1'b0;
        O_err       <= 1'b0;
        O_blank_pos <= 4'd0;
      end else begin
        unique case (state)
          LOAD: begin
            for (int i = 0; i < 9; i++) board[i] <= cell_in[i];
            seen     <= '0;
            bad      <= 1'b0;
            scan_idx <= 4'd0;
          end
          SCAN: begin
            seen <= seen_next;
            bad  <= bad_next;
            if (cur_val == 4'd0) O_blank_pos <= scan_idx + 4'd1;
            if (scan_idx == 4'd8) begin
              O_err    <= !scan_valid;
              O_solved <= scan_valid && board_solved;
            end else begin
              scan_idx <= scan_idx + 4'd1;
            end
          end
          READY: begin
            if (I_move_valid) begin
              if (move_legal) begin
                board[target] <= 4'd0;
                board[pos]    <= board[target];
                O_blank_pos   <= target + 4'd1;
                O_move_ack    <= 1'b1;
                if (O_move_cnt != {CNT_W{1'b1}}) O_move_cnt <= O_move_cnt + CNT_W'(1);
              end else begin
                O_illegal <= 1'b1;
              end
            end
          end
          SETTLE: O_solved <= board_solved;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puzzle_board_keeper.sv
// Bench for puzzle_board_keeper: directed scenarios plus randomized loads and
// moves, all checked against a board-level model that reasons in rows/columns.
module tb_puzzle_board_keeper;

  logic       clk = 1'b0, rst = 1'b0, load = 1'b0, mv = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [3:0] cin [9];
  logic [3:0] c1 [9], c2 [9];
  logic [3:0] bp1, bp2;
  logic [9:0] cnt1;
  logic [1:0] cnt2;
  logic rdy1, busy1, sol1, err1, ack1, ill1;
  logic rdy2, busy2, sol2, err2, ack2, ill2;

  int checks = 0, errors = 0;

  // Model state: board, blank (1..9, 0 unknown), legal-move count, mode.
  // mode: 0 idle, 1 ready, 2 solved, 3 error
  int mb [9];
  int mblank, mcnt, mmode;

  int b_case1 [9] = '{1, 2, 3, 4, 0, 6, 7, 5, 8};
  int b_case2 [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 8};
  int b_case3 [9] = '{0, 3, 6, 2, 5, 8, 1, 4, 7};
  int b_ones  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};

  always #5 clk = ~clk;

  puzzle_board_keeper u_dut (
    .I_clk(clk), .I_rst(rst), .I_load(load),
    .I_cell1(cin[0]), .I_cell2(cin[1]), .I_cell3(cin[2]), .I_cell4(cin[3]),
    .I_cell5(cin[4]), .I_cell6(cin[5]), .I_cell7(cin[6]), .I_cell8(cin[7]),
    .I_cell9(cin[8]), .I_move_valid(mv), .I_move_dir(dir),
    .O_cell1(c1[0]), .O_cell2(c1[1]), .O_cell3(c1[2]), .O_cell4(c1[3]),
    .O_cell5(c1[4]), .O_cell6(c1[5]), .O_cell7(c1[6]), .O_cell8(c1[7]),
    .O_cell9(c1[8]), .O_blank_pos(bp1), .O_move_cnt(cnt1), .O_ready(rdy1),
    .O_busy(busy1), .O_solved(sol1), .O_err(err1), .O_move_ack(ack1),
    .O_illegal(ill1)
  );

  puzzle_board_keeper #(.CNT_W(2)) u_dut2 (
    .I_clk(clk), .I_rst(rst), .I_load(load),
    .I_cell1(cin[0]), .I_cell2(cin[1]), .I_cell3(cin[2]), .I_cell4(cin[3]),
    .I_cell5(cin[4]), .I_cell6(cin[5]), .I_cell7(cin[6]), .I_cell8(cin[7]),
    .I_cell9(cin[8]), .I_move_valid(mv), .I_move_dir(dir),
    .O_cell1(c2[0]), .O_cell2(c2[1]), .O_cell3(c2[2]), .O_cell4(c2[3]),
    .O_cell5(c2[4]), .O_cell6(c2[5]), .O_cell7(c2[6]), .O_cell8(c2[7]),
    .O_cell9(c2[8]), .O_blank_pos(bp2), .O_move_cnt(cnt2), .O_ready(rdy2),
    .O_busy(busy2), .O_solved(sol2), .O_err(err2), .O_move_ack(ack2),
    .O_illegal(ill2)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] pack_dut();
    logic [35:0] r = '0;
    for (int i = 0; i < 9; i++) r = {r[31:0], c1[i]};
    return r;
  endfunction

  function automatic logic [35:0] pack_model();
    logic [35:0] r = '0;
    for (int i = 0; i < 9; i++) r = {r[31:0], 4'(mb[i])};
    return r;
  endfunction

  function automatic bit model_solved();
    for (int i = 0; i < 9; i++)
      if (mb[i] != ((i == 8) ? 0 : i + 1)) return 1'b0;
    return 1'b1;
  endfunction

  // Compare every observable output against the model.
  task automatic check_all(input string tag);
    check({tag, ".board"}, pack_dut(), pack_model());
    check({tag, ".blank"}, bp1, mblank);
    check({tag, ".cnt"}, cnt1, mcnt);
    check({tag, ".cnt2"}, cnt2, (mcnt > 3) ? 3 : mcnt);
    check({tag, ".ready"}, rdy1, mmode == 1);
    check({tag, ".solved"}, sol1, mmode == 2);
    check({tag, ".err"}, err1, mmode == 3);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mblank = 0; mcnt = 0; mmode = 0;
  endtask

  // A board is valid iff each value 0..8 appears exactly once.
  task automatic model_load(input int v[9]);
    int  count [16];
    bit  valid = 1'b1;
    for (int i = 0; i < 16; i++) count[i] = 0;
    mblank = 0;
    for (int i = 0; i < 9; i++) begin
      mb[i] = v[i];
      count[v[i]]++;
      if (v[i] == 0) mblank = i + 1;
    end
    for (int i = 0; i < 16; i++)
      if ((i <= 8 && count[i] != 1) || (i > 8 && count[i] != 0)) valid = 1'b0;
    mcnt  = 0;
    mmode = !valid ? 3 : (model_solved() ? 2 : 1);
  endtask

  task automatic do_load(input string tag, input int v[9]);
    for (int i = 0; i < 9; i++) cin[i] = 4'(v[i]);
    load = 1'b1;
    step();                       // edge k
    load = 1'b0;
    check({tag, ".cnt_clr"}, cnt1, 0);
    check({tag, ".busy_k"}, busy1, 1);
    for (int k = 1; k <= 9; k++) begin
      step();
      check({tag, ".busy"}, busy1, 1);
      check({tag, ".not_ready"}, rdy1 | err1, 0);
    end
    step();                       // edge k+10
    model_load(v);
    check_all(tag);
    check({tag, ".busy_done"}, busy1, 0);
  endtask

  // Blank moves in direction d; legality judged from row/column bounds.
  task automatic do_move(input string tag, input int d);
    bit exp_ack = 1'b0, exp_ill = 1'b0;
    int r, c, nr, nc, np;
    if (mmode == 1) begin
      r = (mblank - 1) / 3; c = (mblank - 1) % 3;
      nr = r + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
      nc = c + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
      if (nr >= 0 && nr <= 2 && nc >= 0 && nc <= 2) begin
        np = nr * 3 + nc;
        mb[mblank - 1] = mb[np];
        mb[np] = 0;
        mblank = np + 1;
        mcnt++;
        exp_ack = 1'b1;
      end else begin
        exp_ill = 1'b1;
      end
    end
    mv = 1'b1; dir = 2'(d);
    step();                       // edge t
    mv = 1'b0;
    check({tag, ".ack"}, ack1, exp_ack);
    check({tag, ".illegal"}, ill1, exp_ill);
    check({tag, ".busy_settle"}, busy1, exp_ack);
    check({tag, ".board_t"}, pack_dut(), pack_model());
    check({tag, ".blank_t"}, bp1, mblank);
    check({tag, ".cnt_t"}, cnt1, mcnt);
    step();                       // edge t+1
    if (exp_ack) mmode = model_solved() ? 2 : 1;
    check({tag, ".ack_off"}, ack1 | ill1, 0);
    check_all(tag);
  endtask

  initial begin
    int rb [9];
    int tmp, j;
    for (int i = 0; i < 9; i++) cin[i] = 4'd0;

    // Reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_reset();
    check_all("reset");
    check("reset.flags", {busy1, ack1, ill1}, 3'b000);
    do_move("idle_move", 3);

    // Case 1: load latency, blank at centre
    do_load("case1", b_case1);

    // Case 2: one move right solves, then moves are ignored
    do_load("case2", b_case2);
    do_move("case2.right", 3);
    check("case2.cell9", c1[8], 0);
    check("case2.solved", sol1, 1);
    do_move("case2.frozen", 1);

    // Case 3: edge moves rejected, then a legal one
    do_load("case3", b_case3);
    do_move("case3.up", 0);
    do_move("case3.left", 2);
    do_move("case3.down", 1);

    // Case 4: invalid board, moves ignored, reload clears error
    do_load("case4", b_ones);
    do_move("case4.move", 1);
    do_load("case4.reload", b_case1);

    // Case 5a: second load four cycles into the scan restarts it
    for (int i = 0; i < 9; i++) cin[i] = 4'(b_case1[i]);
    load = 1'b1; step(); load = 1'b0;
    for (int k = 0; k < 5; k++) step();
    do_load("abort", b_case1);

    // Case 5b: reset during SETTLE
    mv = 1'b1; dir = 2'd2;
    step();
    mv = 1'b0;
    check("settle.busy", busy1, 1);
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    check_all("rst_settle");
    check("rst_settle.flags", {busy1, ack1, ill1}, 3'b000);
    do_move("rst_settle.move", 2);

    // Case 6: saturation of the narrow counter
    do_load("sat", b_case1);
    for (int k = 0; k < 5; k++) do_move("sat.mv", (k % 2 == 0) ? 2 : 3);

    // Randomized boards and moves
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 9; i++) rb[i] = i;
      for (int i = 8; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = rb[i]; rb[i] = rb[j]; rb[j] = tmp;
      end
      if ($urandom_range(3, 0) == 0) rb[$urandom_range(8, 0)] = int'($urandom_range(15, 0));
      do_load("rand.load", rb);
      for (int m = 0; m < 20; m++) do_move("rand.move", int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puzzle_board_keeper.md
Name: puzzle_board_keeper

Overview:
- Holds the live 3x3 sliding-puzzle board.
- Loads a preset layout (cells 1..9, row-major, value 0 = blank) from the preset driver on request, and validates that it is a permutation of 0..8.
- Then applies player moves by swapping the blank with a neighbour, counts moves and flags the solved state.
- Sits between the preset driver and the display/keypad logic.

Parameters:
- CNT_W, 10, width of the move counter; the counter saturates at its maximum value.

Ports:
- I_clk, input, 1, system clock; all logic is on the rising edge.
- I_rst, input, 1, synchronous active-high reset.
- I_load, input, 1, single-cycle request to capture the I_cell* inputs.
- I_cell1..I_cell9, input, 4 each, preset cell values from the preset driver.
- I_move_valid, input, 1, move request strobe.
- I_move_dir, input, 2, direction the blank moves: 0 = up, 1 = down, 2 = left, 3 = right.
- O_cell1..O_cell9, output, 4 each, current board contents.
- O_blank_pos, output, 4, index 1..9 of the blank; 0 when unknown.
- O_move_cnt, output, CNT_W, number of legal moves since the last load.
- O_ready, output, 1, high when a move is accepted this cycle (state READY).
- O_busy, output, 1, high in LOAD, SCAN and SETTLE.
- O_solved, output, 1, board equals 1,2,3,4,5,6,7,8,0.
- O_err, output, 1, loaded board is not a permutation of 0..8.
- O_move_ack, output, 1, one-cycle pulse: a legal move was applied.
- O_illegal, output, 1, one-cycle pulse: a move was rejected because it is off the edge.

Behaviour:
- Reset (I_rst high at an edge):
  - State goes to IDLE.
  - All O_cell*, O_blank_pos and O_move_cnt go to 0.
  - O_ready, O_busy, O_solved, O_err, O_move_ack and O_illegal go to 0.
  - Reset overrides everything, including an operation in progress.
- States: IDLE, LOAD, SCAN, READY, SETTLE, SOLVED, ERR.
- I_load sampled high in any state:
  - Next state is LOAD.
  - O_move_cnt, O_solved, O_err and O_blank_pos are cleared.
  - An in-progress scan or move is aborted.
  - I_load has priority over I_move_valid in the same cycle.
- LOAD (1 cycle):
  - Registers I_cell1..9 into the board.
  - Clears the 9-bit seen mask and the scan index.
  - Goes to SCAN.
- SCAN (9 cycles, index 0..8):
  - Each cycle, cell[index] sets bit value in the seen mask. Values greater than 8 mark the board invalid.
  - When the value is 0, O_blank_pos is set to index+1.
  - After index 8: if the mask is all ones and no value exceeded 8, go to READY, else go to ERR.
  - O_solved is registered on the same transition.
  - If the board is valid and already solved, go to SOLVED instead of READY.
- Load latency: with I_load sampled at edge k, O_ready or O_err is high from edge k+10.
- READY with I_move_valid sampled high, blank at row r, column c (0-based):
  - Up is legal iff r > 0 (swap with pos-3).
  - Down is legal iff r < 2 (swap with pos+3).
  - Left is legal iff c > 0 (swap with pos-1).
  - Right is legal iff c < 2 (swap with pos+1).
- Legal move, sampled at edge t:
  - At edge t the two cells are swapped, O_blank_pos is updated and O_move_cnt is incremented (saturating).
  - O_move_ack is high for the cycle t..t+1.
  - State goes to SETTLE.
- SETTLE (1 cycle):
  - O_solved is registered as the board-vs-solved compare.
  - Next state is SOLVED if solved, else READY.
- Illegal move:
  - Board and counter are unchanged.
  - O_illegal pulses for 1 cycle.
  - State stays READY.
- Moves are ignored (no ack, no illegal pulse) in IDLE, LOAD, SCAN, SETTLE, SOLVED and ERR.
- SOLVED: board frozen, O_solved held at 1 until the next load or reset.
- ERR: O_err held at 1 and the board holds the captured values until the next load or reset.
- O_ready is 1 only in READY.
- O_busy is 1 only in LOAD, SCAN and SETTLE.

Test Plan:
1. Load 1,2,3,4,0,6,7,5,8 at edge k.
   - O_busy is high for k+1..k+9.
   - From k+10: O_ready=1, O_blank_pos=5, O_solved=0, O_move_cnt=0.
2. Load 1,2,3,4,5,6,7,0,8, then move right.
   - Cell8=8, cell9=0, O_blank_pos=9, O_move_cnt=1, 1-cycle ack.
   - Next cycle O_solved=1 and state is SOLVED.
   - A further move down produces no ack and no illegal pulse.
3. Load 0,3,6,2,5,8,1,4,7.
   - Move up, then move left: each gives an O_illegal pulse, count stays 0.
   - Move down: cell1=2, cell4=0, O_blank_pos=4, count=1.
4. Load all cells = 1.
   - At k+10: O_err=1, O_ready=0.
   - Moves are ignored.
   - A reload of the case-1 board clears O_err.
5. Abort and reset cases:
   - Pulse I_load again 4 cycles into SCAN: the scan restarts and the ready time counts from the second load.
   - Assert I_rst during SETTLE: all outputs are 0 next cycle and the state is IDLE.
6. With CNT_W=2, perform 5 legal alternating left/right moves on the case-1 board: O_move_cnt reads 1,2,3,3,3.
